// File: rtl/gg_mmu_pkg.sv
// Game Gear MMU shared definitions.
// Address constants, reset values and region decode.
package gg_mmu_pkg;

  localparam logic [15:0] MAP_CTRL_A  = 16'hFFFC;
  localparam logic [15:0] UNBANKED_TOP = 16'h03FF;
  localparam logic [1:0]  RAM_SEL     = 2'b11;

  localparam logic [7:0] CTRL_RST  = 8'h00;
  localparam logic [7:0] SLOT0_RST = 8'h00;
  localparam logic [7:0] SLOT1_RST = 8'h01;
  localparam logic [7:0] SLOT2_RST = 8'h02;

  localparam logic [7:0] PORT_START = 8'h00;
  localparam logic [7:0] START_VAL  = 8'hC0;
  localparam logic [7:0] REG_LO     = 8'h01;
  localparam logic [7:0] REG_HI     = 8'h05;
  localparam logic [7:0] WREG_HI    = 8'h06;
  localparam logic [7:0] OPEN_BUS   = 8'hFF;
  localparam logic [1:0] IO_VCNT    = 2'b01;
  localparam logic [1:0] IO_VDP     = 2'b10;

  typedef enum logic [2:0] {
    RG_FIXED,
    RG_SLOT0,
    RG_SLOT1,
    RG_SLOT2,
    RG_RAM
  } region_e;

  function automatic region_e region_of(input logic [15:0] a);
    region_e r;
    if (a[15:14] == RAM_SEL) r = RG_RAM;
    else if (a <= UNBANKED_TOP) r = RG_FIXED;
    else if (a[15:14] == 2'b00) r = RG_SLOT0;
    else if (a[15:14] == 2'b01) r = RG_SLOT1;
    else r = RG_SLOT2;
    return r;
  endfunction

  function automatic logic [7:0] io_reset(input logic [2:0] idx);
    logic [7:0] v;
    case (idx)
      3'd1: v = 8'h7F;
      3'd2: v = 8'hFF;
      3'd4: v = 8'hFF;
      3'd6: v = 8'hFF;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/gg_mmu_if.sv
// Z80 bus and slave-side signal bundle.
// slave = the MMU, master = the surrounding system.
interface gg_mmu_if;
  logic [15:0] z80_addr;
  logic [7:0]  z80_do;
  logic [7:0]  z80_di;
  logic        z80_mem_rd;
  logic        z80_mem_wr;
  logic        z80_io_rd;
  logic        z80_io_wr;
  logic        ram_we;
  logic [7:0]  ram_di;
  logic [7:0]  ram_do;
  logic [12:0] ram_addr;
  logic [7:0]  cart_di;
  logic [7:0]  cart_do;
  logic [21:0] cart_addr;
  logic        vdp_control_wr;
  logic        vdp_control_rd;
  logic [7:0]  vdp_control_o;
  logic        vdp_data_wr;
  logic        vdp_data_rd;
  logic [7:0]  vdp_data_o;
  logic [7:0]  vdp_v_counter;
  logic [7:0]  vdp_h_counter;
  logic [7:0]  mapper_ctrl;

  modport slave (
    input  z80_addr, z80_do, z80_mem_rd, z80_mem_wr,
    input  z80_io_rd, z80_io_wr,
    input  ram_do, cart_do, vdp_control_o, vdp_data_o,
    input  vdp_v_counter, vdp_h_counter,
    output z80_di, ram_we, ram_di, ram_addr,
    output cart_di, cart_addr,
    output vdp_control_wr, vdp_control_rd,
    output vdp_data_wr, vdp_data_rd, mapper_ctrl
  );

  modport master (
    output z80_addr, z80_do, z80_mem_rd, z80_mem_wr,
    output z80_io_rd, z80_io_wr,
    output ram_do, cart_do, vdp_control_o, vdp_data_o,
    output vdp_v_counter, vdp_h_counter,
    input  z80_di, ram_we, ram_di, ram_addr,
    input  cart_di, cart_addr,
    input  vdp_control_wr, vdp_control_rd,
    input  vdp_data_wr, vdp_data_rd, mapper_ctrl
  );
endinterface

// File: rtl/gg_mapper.sv
// Sega-style 3-slot cartridge mapper.
// Holds ctrl/slot registers and forms the cart byte address.
module gg_mapper
  import gg_mmu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [7:0]  data,
  input  logic        wr,
  output logic [7:0]  ctrl,
  output logic [21:0] cart_addr
);

  logic [7:0] slot0;
  logic [7:0] slot1;
  logic [7:0] slot2;
  logic [7:0] bank;

  // Capture writes to the top four bytes of the address space.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl  <= CTRL_RST;
      slot0 <= SLOT0_RST;
      slot1 <= SLOT1_RST;
      slot2 <= SLOT2_RST;
    end else if (wr && addr >= MAP_CTRL_A) begin
      case (addr[1:0])
        2'd0: ctrl  <= data;
        2'd1: slot0 <= data;
        2'd2: slot1 <= data;
        default: slot2 <= data;
      endcase
    end
  end

  // Pick the bank for the addressed 16 KB window.
  always_comb begin
    bank = 8'h00;
    unique case (region_of(addr))
      RG_SLOT0: bank = slot0;
      RG_SLOT1: bank = slot1;
      RG_SLOT2: bank = slot2;
      default:  bank = 8'h00;
    endcase
    cart_addr = {bank, addr[13:0]};
  end

endmodule

// File: rtl/gg_mmu.sv
// Game Gear memory / I-O management unit.
// Decodes Z80 cycles, drives slaves, muxes read data.
module gg_mmu
  import gg_mmu_pkg::*;
(
  input logic clk,
  input logic rst,
  gg_mmu_if.slave bus
);

  logic [7:0] port;
  logic       mem_cyc;
  logic       is_ram;
  logic       vdp_sel;
  logic       reg_sel;
  logic [7:0] io_reg [1:6];
  logic [7:0] io_data;

  assign port    = bus.z80_addr[7:0];
  assign mem_cyc = bus.z80_mem_rd | bus.z80_mem_wr;
  assign is_ram  = bus.z80_addr[15:14] == RAM_SEL;
  assign vdp_sel = port[7:6] == IO_VDP;
  assign reg_sel = port >= REG_LO && port <= WREG_HI;

  assign bus.ram_we   = bus.z80_mem_wr & is_ram;
  assign bus.ram_di   = bus.z80_do;
  assign bus.cart_di  = bus.z80_do;
  assign bus.ram_addr = bus.z80_addr[12:0];

  assign bus.vdp_data_rd    = bus.z80_io_rd & vdp_sel & ~port[0];
  assign bus.vdp_data_wr    = bus.z80_io_wr & vdp_sel & ~port[0];
  assign bus.vdp_control_rd = bus.z80_io_rd & vdp_sel & port[0];
  assign bus.vdp_control_wr = bus.z80_io_wr & vdp_sel & port[0];

  gg_mapper u_mapper (
    .clk       (clk),
    .rst       (rst),
    .addr      (bus.z80_addr),
    .data      (bus.z80_do),
    .wr        (bus.z80_mem_wr),
    .ctrl      (bus.mapper_ctrl),
    .cart_addr (bus.cart_addr)
  );

  // System I/O registers; a colliding mem cycle blocks the write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i <= 6; i++)
        io_reg[i] <= io_reset(3'(i));
    end else if (bus.z80_io_wr && !mem_cyc && reg_sel) begin
      io_reg[port[2:0]] <= bus.z80_do;
    end
  end

  // I/O read map.
  always_comb begin
    io_data = OPEN_BUS;
    unique case (1'b1)
      port == PORT_START:
        io_data = START_VAL;
      port >= REG_LO && port <= REG_HI:
        io_data = io_reg[port[2:0]];
      port[7:6] == IO_VCNT:
        io_data = port[0] ? bus.vdp_h_counter : bus.vdp_v_counter;
      vdp_sel:
        io_data = port[0] ? bus.vdp_control_o : bus.vdp_data_o;
      default:
        io_data = OPEN_BUS;
    endcase
  end

  // Z80 read data; memory wins over I/O.
  always_comb begin
    bus.z80_di = OPEN_BUS;
    if (bus.z80_mem_rd)
      bus.z80_di = is_ram ? bus.ram_do : bus.cart_do;
    else if (bus.z80_io_rd)
      bus.z80_di = io_data;
  end

endmodule

// File: tb/tb_gg_mmu.sv
// Self-checking bench for gg_mmu.
// Scoreboard queue fed by stimulus, drained by a monitor.
module tb_gg_mmu;

  typedef struct {
    string       name;
    logic [7:0]  di;
    logic        chk_cart;
    logic [21:0] cart;
    logic [12:0] ram_addr;
    logic        ram_we;
    logic [3:0]  vdp;
    logic [7:0]  ctrl;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t q[$];

  int   m_slot [3];
  int   m_ctrl;
  int   m_io [1:5];

  gg_mmu_if bus();

  gg_mmu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ctrl = 0;
    m_slot[0] = 0;
    m_slot[1] = 1;
    m_slot[2] = 2;
    m_io[1] = 'h7F;
    m_io[2] = 'hFF;
    m_io[3] = 'h00;
    m_io[4] = 'hFF;
    m_io[5] = 'h00;
  endtask

  function automatic int io_read(int p);
    if (p == 0) return 'hC0;
    if (p >= 1 && p <= 5) return m_io[p];
    if (p >= 'h40 && p < 'h80)
      return (p % 2 == 0) ? int'(bus.vdp_v_counter) : int'(bus.vdp_h_counter);
    if (p >= 'h80 && p < 'hC0)
      return (p % 2 == 0) ? int'(bus.vdp_data_o) : int'(bus.vdp_control_o);
    return 'hFF;
  endfunction

  task automatic issue(string nm, bit r, bit mr, bit mw, bit ir, bit iw,
                       int a, int d, bit rnd, int sd);
    exp_t e;
    int   p;
    bit   vdp;
    @(posedge clk);
    #1;
    rst = r;
    if (r) model_reset();
    bus.z80_addr   = 16'(a);
    bus.z80_do     = 8'(d);
    bus.z80_mem_rd = mr;
    bus.z80_mem_wr = mw;
    bus.z80_io_rd  = ir;
    bus.z80_io_wr  = iw;
    if (rnd) begin
      bus.cart_do       = 8'($urandom);
      bus.ram_do        = 8'($urandom);
      bus.vdp_data_o    = 8'($urandom);
      bus.vdp_control_o = 8'($urandom);
      bus.vdp_v_counter = 8'($urandom);
      bus.vdp_h_counter = 8'($urandom);
    end else begin
      bus.cart_do       = 8'(sd);
      bus.ram_do        = 8'(sd + 'h40);
      bus.vdp_data_o    = 8'(sd);
      bus.vdp_control_o = 8'(sd + 'h80);
      bus.vdp_v_counter = 8'(sd);
      bus.vdp_h_counter = 8'(sd + 'hC0);
    end
    if (!(mr || mw || ir || iw)) return;
    p = a % 256;
    e.name = nm;
    if (mr) e.di = (a >= 'hC000) ? bus.ram_do : bus.cart_do;
    else if (ir) e.di = 8'(io_read(p));
    else e.di = 8'hFF;
    e.chk_cart = (mr || mw) && a < 'hC000;
    if (a < 'h400) e.cart = 22'(a % 16384);
    else e.cart = 22'(m_slot[a / 16384 % 4 == 3 ? 0 : a / 16384] * 16384
                      + a % 16384);
    e.ram_addr = 13'(a % 8192);
    e.ram_we = mw && a >= 'hC000;
    vdp = p >= 'h80 && p < 'hC0;
    e.vdp = {ir && vdp && p % 2 == 0, iw && vdp && p % 2 == 0,
             ir && vdp && p % 2 == 1, iw && vdp && p % 2 == 1};
    e.ctrl = 8'(m_ctrl);
    q.push_back(e);
    if (!r) begin
      if (mw && a >= 'hFFFC) begin
        if (a == 'hFFFC) m_ctrl = d;
        else m_slot[a - 'hFFFD] = d;
      end
      if (iw && !(mr || mw) && p >= 1 && p <= 5) m_io[p] = d;
    end
  endtask

  // Monitor: any active strobe presents a cycle to score.
  always @(negedge clk) begin
    exp_t e;
    if (bus.z80_mem_rd || bus.z80_mem_wr || bus.z80_io_rd || bus.z80_io_wr) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard: got cycle with empty queue, required none");
      end else begin
        e = q.pop_front();
        chk({e.name, "/di"}, 32'(bus.z80_di), 32'(e.di));
        chk({e.name, "/ram_addr"}, 32'(bus.ram_addr), 32'(e.ram_addr));
        chk({e.name, "/ram_we"}, 32'(bus.ram_we), 32'(e.ram_we));
        chk({e.name, "/vdp"}, 32'({bus.vdp_data_rd, bus.vdp_data_wr,
            bus.vdp_control_rd, bus.vdp_control_wr}), 32'(e.vdp));
        chk({e.name, "/ctrl"}, 32'(bus.mapper_ctrl), 32'(e.ctrl));
        chk({e.name, "/wdata"}, 32'({bus.ram_di, bus.cart_di}),
            32'({bus.z80_do, bus.z80_do}));
        if (e.chk_cart)
          chk({e.name, "/cart_addr"}, 32'(bus.cart_addr), 32'(e.cart));
      end
    end
  end

  initial begin
    int a;
    int k;
    bus.z80_addr = '0;
    bus.z80_do = '0;
    bus.z80_mem_rd = 0;
    bus.z80_mem_wr = 0;
    bus.z80_io_rd = 0;
    bus.z80_io_wr = 0;
    bus.cart_do = '0;
    bus.ram_do = '0;
    bus.vdp_data_o = '0;
    bus.vdp_control_o = '0;
    bus.vdp_v_counter = '0;
    bus.vdp_h_counter = '0;
    model_reset();
    #2;
    chk("reset/di", 32'(bus.z80_di), 32'hFF);
    chk("reset/ram_we", 32'(bus.ram_we), 0);
    chk("reset/ctrl", 32'(bus.mapper_ctrl), 0);
    chk("reset/vdp", 32'({bus.vdp_data_rd, bus.vdp_data_wr,
        bus.vdp_control_rd, bus.vdp_control_wr}), 0);
    //      name          r  mr mw ir iw addr     data  rnd sd
    issue("idle",        0, 0, 0, 0, 0, 0,       0,    0, 0);
    issue("rd4123",      0, 1, 0, 0, 0, 'h4123, 0,    0, 'h5A);
    issue("wr_slot2",    0, 0, 1, 0, 0, 'hFFFF, 'h07, 0, 0);
    issue("rd8010",      0, 1, 0, 0, 0, 'h8010, 0,    0, 0);
    issue("rd0123",      0, 1, 0, 0, 0, 'h0123, 0,    0, 'h21);
    issue("wr_ram",      0, 0, 1, 0, 0, 'hC005, 'h33, 0, 0);
    issue("rd_mirror",   0, 1, 0, 0, 0, 'hE005, 0,    0, 'h77);
    issue("io_wr_bf",    0, 0, 0, 0, 1, 'h00BF, 'hAB, 0, 0);
    issue("io_rd_be",    0, 0, 0, 1, 0, 'h00BE, 0,    0, 'h12);
    issue("io_rd_7e",    0, 0, 0, 1, 0, 'h007E, 0,    0, 'hC3);
    issue("io_rd_7f",    0, 0, 0, 1, 0, 'h007F, 0,    0, 'hC3);
    issue("io_rd_00",    0, 0, 0, 1, 0, 'h0000, 0,    0, 0);
    issue("io_rd_06",    0, 0, 0, 1, 0, 'h0006, 0,    0, 0);
    issue("io_wr_01",    0, 0, 0, 0, 1, 'h0001, 'h42, 0, 0);
    issue("io_rd_01",    0, 0, 0, 1, 0, 'h0001, 0,    0, 0);
    issue("both",        0, 1, 0, 0, 1, 'h4001, 'h99, 0, 'h3C);
    issue("io_rd_01b",   0, 0, 0, 1, 0, 'h0001, 0,    0, 0);
    issue("wr_ctrl",     0, 0, 1, 0, 0, 'hFFFC, 'h5C, 0, 0);
    issue("rd_ctrl",     0, 1, 0, 0, 0, 'h0200, 0,    0, 0);
    issue("rst_io01",    1, 0, 0, 1, 0, 'h0001, 0,    0, 0);
    issue("rst_slot2",   1, 1, 0, 0, 0, 'h8010, 0,    0, 0);
    issue("post_rst",    0, 1, 0, 0, 0, 'h4123, 0,    0, 'h5A);
    for (int i = 0; i < 400; i++) begin
      k = $urandom_range(0, 4);
      if ($urandom_range(0, 3) == 0) a = 'hFFFC + $urandom_range(0, 3);
      else a = $urandom_range(0, 'hFFFF);
      issue("rand", 0, k == 0, k == 1, k == 2, k == 3, a,
            $urandom_range(0, 255), 1, 0);
    end
    issue("drain", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("queue_empty", 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gg_mmu.md
# gg_mmu

Memory/I-O management unit for the Game Gear core. It sits between the Z80 bus strobes and the system slaves: 8 KB work RAM, cartridge ROM behind a Sega-style 3-slot mapper, the VDP data and control ports, the VDP counters, and the Game Gear system I/O registers. It decodes every Z80 memory and I/O cycle, drives per-slave address, data and strobes, and muxes read data back onto `z80_di`.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  reset, asynchronous, active-high.
- `z80_addr`  in  16  Z80 address bus.
- `z80_do`  in  8  Z80 write data.
- `z80_di`  out  8  Z80 read data.
- `z80_mem_rd`, `z80_mem_wr`, `z80_io_rd`, `z80_io_wr`  in  1 each  decoded Z80 cycle strobes, level, possibly held several clocks.
- `ram_we`  out  1  RAM write enable.
- `ram_di`  out  8  RAM write data.
- `ram_do`  in  8  RAM read data.
- `ram_addr`  out  13  RAM address.
- `cart_di`  out  8  cartridge write data.
- `cart_do`  in  8  cartridge read data.
- `cart_addr`  out  22  mapped cartridge byte address.
- `vdp_control_wr`, `vdp_control_rd`  out  1  VDP control-port strobes.
- `vdp_control_o`  in  8  VDP status byte.
- `vdp_data_wr`, `vdp_data_rd`  out  1  VDP data-port strobes.
- `vdp_data_o`  in  8  VDP read data.
- `vdp_v_counter`, `vdp_h_counter`  in  8  VDP beam counters.

## Operation
Memory map, all decode combinational:
- 0x0000–0x03FF: cart, `cart_addr` = {8'h00, addr[13:0]}. Unbanked.
- 0x0400–0x3FFF: cart, `cart_addr` = {slot0, addr[13:0]}.
- 0x4000–0x7FFF: cart, `cart_addr` = {slot1, addr[13:0]}.
- 0x8000–0xBFFF: cart, `cart_addr` = {slot2, addr[13:0]}.
- 0xC000–0xFFFF: RAM. `ram_addr` = addr[12:0], mirrored every 8 KB.
- `ram_di` = `cart_di` = `z80_do`.
- `ram_we` = mem_wr & addr[15:14]==2'b11.
- Cart writes are otherwise ignored.

Mapper registers. A memory write to any of these addresses also writes RAM.
- 0xFFFC: ctrl. Stored only; reset 0x00.
- 0xFFFD: slot0. Reset 0x00.
- 0xFFFE: slot1. Reset 0x01.
- 0xFFFF: slot2. Reset 0x02.

I/O map. Only addr[7:0] is decoded.
- 0x00: read 0xC0. Start button released, export region.
- 0x01–0x05: read/write registers. Reset values 0x7F, 0xFF, 0x00, 0xFF, 0x00.
- 0x06: write-only stereo register, reset 0xFF; reads return 0xFF.
- 0x07–0x3F: reads return 0xFF; writes ignored.
- 0x40–0x7F: reads return `vdp_v_counter` on even addresses and `vdp_h_counter` on odd. Writes (PSG) ignored.
- 0x80–0xBF: even = VDP data, odd = VDP control. `vdp_*_rd` = io_rd & decode; `vdp_*_wr` = io_wr & decode. Read data comes from `vdp_data_o` or `vdp_control_o`.
- 0xC0–0xFF: joypad. Reads return 0xFF.

`z80_di` mux:
- During mem_rd: RAM or cart data.
- During io_rd: the I/O map above.
- Otherwise: 0xFF.

## Timing
- All decode, strobes, addresses and `z80_di` are combinational from inputs. Zero latency.
- Register writes (mapper and I/O) take effect on the posedge `clk` where the write strobe is high.
- A held strobe rewrites the same value each cycle; this is harmless.
- A new slot value affects `cart_addr` from the cycle after the capturing edge.
- `rst` asserted at any time immediately forces all registers to their reset values. Outputs then follow combinationally, with no clock required.
- Mem and io strobes are never both active. If they are, mem has priority for `z80_di`, and I/O register writes are suppressed.
- Strobe outputs are low whenever the corresponding input strobe is low, including during reset.

## Structure
- Shared package `gg_mmu_pkg`: port-address constants, mapper register addresses, register reset values, region boundary constants.
- One sub-module: `gg_mapper`. It holds the four mapper registers and the slot-select/`cart_addr` computation.
- I/O decode and the read mux stay in the top module.

## Test plan
- Reset, then mem_rd at 0x4123 with `cart_do`=0x5A → `cart_addr`=0x04123, `z80_di`=0x5A.
- mem_wr 0x07 to 0xFFFF, then mem_rd at 0x8010 → `cart_addr`=0x1C010. The write also produces `ram_we`=1 with `ram_addr`=0x1FFF.
- mem_wr 0x33 to 0xC005, then mem_rd at 0xE005 (mirror) → `ram_addr`=0x0005 both times; `z80_di`=`ram_do`.
- io_wr 0xAB to port 0xBF → `vdp_control_wr`=1 and `vdp_data_wr`=0. io_rd at port 0xBE with `vdp_data_o`=0x12 → `vdp_data_rd`=1, `z80_di`=0x12.
- io_rd at port 0x7E with `vdp_v_counter`=0xC3 → `z80_di`=0xC3. io_rd at port 0x7F → `vdp_h_counter`.
- io_wr 0x42 to port 0x01, then io_rd port 0x01 → `z80_di`=0x42. Assert `rst` mid-test → port 0x01 reads 0x7F and slot2 returns to 0x02 without a clock edge.
